// File: rtl/seg7_pkg.sv
// Shared 7-segment constants and types for the segment mux capture path.
// Segment order is gfedcba, active-high.
package seg7_pkg;

   typedef logic [6:0] seg7_t;

   localparam logic [1:0] SEL_HI = 2'b01;
   localparam logic [1:0] SEL_LO = 2'b10;

   localparam seg7_t SEG7_0 = 7'h3F;
   localparam seg7_t SEG7_1 = 7'h06;
   localparam seg7_t SEG7_2 = 7'h5B;
   localparam seg7_t SEG7_3 = 7'h4F;
   localparam seg7_t SEG7_4 = 7'h66;
   localparam seg7_t SEG7_5 = 7'h6D;
   localparam seg7_t SEG7_6 = 7'h7D;
   localparam seg7_t SEG7_7 = 7'h07;
   localparam seg7_t SEG7_8 = 7'h7F;
   localparam seg7_t SEG7_9 = 7'h6F;
   localparam seg7_t SEG7_A = 7'h77;
   localparam seg7_t SEG7_B = 7'h7C;
   localparam seg7_t SEG7_C = 7'h39;
   localparam seg7_t SEG7_D = 7'h5E;
   localparam seg7_t SEG7_E = 7'h79;
   localparam seg7_t SEG7_F = 7'h71;

endpackage

// File: rtl/seg7_to_hex.sv
// Combinational 7-segment to hex decoder; ok=0 for any pattern
// outside the 16 legal glyphs.
module seg7_to_hex
   import seg7_pkg::*;
(
   input  seg7_t      seg,
   output logic [3:0] nibble,
   output logic       ok
);

   always_comb begin
      nibble = 4'h0;
      ok     = 1'b1;
      case (seg)
         SEG7_0:  nibble = 4'h0;
         SEG7_1:  nibble = 4'h1;
         SEG7_2:  nibble = 4'h2;
         SEG7_3:  nibble = 4'h3;
         SEG7_4:  nibble = 4'h4;
         SEG7_5:  nibble = 4'h5;
         SEG7_6:  nibble = 4'h6;
         SEG7_7:  nibble = 4'h7;
         SEG7_8:  nibble = 4'h8;
         SEG7_9:  nibble = 4'h9;
         SEG7_A:  nibble = 4'hA;
         SEG7_B:  nibble = 4'hB;
         SEG7_C:  nibble = 4'hC;
         SEG7_D:  nibble = 4'hD;
         SEG7_E:  nibble = 4'hE;
         SEG7_F:  nibble = 4'hF;
         default: ok     = 1'b0;
      endcase
   end

endmodule

// File: rtl/seg_mux_capture.sv
// Samples muxed 7-seg/select lines, waits for them to settle and rebuilds
// a two-digit frame. Optional watchdog: SEG_MUX_CAPTURE_TIMEOUT_EN.
module seg_mux_capture
   import seg7_pkg::*;
#(
   parameter int unsigned STABLE_CYCLES  = 256,
   parameter int unsigned TIMEOUT_CYCLES = 4194304
) (
   input  logic       CLOCK_50,
   input  logic       reset,
   input  logic [6:0] seg_in,
   input  logic [1:0] sel_in,
   output logic [3:0] digit_hi,
   output logic [3:0] digit_lo,
   output logic       valid_hi,
   output logic       valid_lo,
   output logic       frame_valid,
   output logic [7:0] frame_data,
   output logic       seg_err,
   output logic       sel_err,
   output logic       stale
);

   localparam logic [15:0] STAB_MAX  = 16'(STABLE_CYCLES);
   localparam logic [15:0] STAB_LAST = 16'(STABLE_CYCLES - 1);

   logic [8:0]  sync1_q, sync1_d;
   logic [8:0]  sync2_q, sync2_d;
   logic [8:0]  prev_q, prev_d;
   logic [15:0] stab_cnt_q, stab_cnt_d;
   logic [3:0]  digit_hi_q, digit_hi_d;
   logic [3:0]  digit_lo_q, digit_lo_d;
   logic        valid_hi_q, valid_hi_d;
   logic        valid_lo_q, valid_lo_d;
   logic        got_hi_q, got_hi_d;
   logic        got_lo_q, got_lo_d;
   logic        frame_valid_q, frame_valid_d;
   logic [7:0]  frame_data_q, frame_data_d;
   logic        seg_err_q, seg_err_d;
   logic        sel_err_q, sel_err_d;

   logic [8:0]  cur;
   logic [1:0]  cur_sel;
   seg7_t       cur_seg;
   logic        same;
   logic        strobe;
   logic [3:0]  dec_nib;
   logic        dec_ok;

   assign cur     = sync2_q;
   assign cur_sel = cur[8:7];
   assign cur_seg = cur[6:0];
   assign same    = (cur == prev_q);
   // One strobe per stable window: saturation holds the count past LAST.
   assign strobe  = same && (stab_cnt_q == STAB_LAST);

   seg7_to_hex u_dec (
      .seg    (cur_seg),
      .nibble (dec_nib),
      .ok     (dec_ok)
   );

`ifdef SEG_MUX_CAPTURE_TIMEOUT_EN
   localparam logic [31:0] WD_MAX = 32'(TIMEOUT_CYCLES);

   logic [31:0] wd_q, wd_d;
   logic        stale_q, stale_d;
   logic        wd_hit;

   assign wd_hit = (wd_q == WD_MAX);
   assign stale  = stale_q;

   always_comb begin
      wd_d = wd_q;
      if (strobe)
         wd_d = '0;
      else if (!wd_hit)
         wd_d = wd_q + 32'd1;
   end

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         wd_q    <= '0;
         stale_q <= 1'b0;
      end else begin
         wd_q    <= wd_d;
         stale_q <= stale_d;
      end
   end
`else
   // Watchdog absent: the parameter only exists to keep one interface.
   assign stale = (TIMEOUT_CYCLES == 0) && 1'b0;
`endif

   always_comb begin
      sync1_d       = {sel_in, seg_in};
      sync2_d       = sync1_q;
      prev_d        = cur;
      stab_cnt_d    = stab_cnt_q;
      digit_hi_d    = digit_hi_q;
      digit_lo_d    = digit_lo_q;
      valid_hi_d    = valid_hi_q;
      valid_lo_d    = valid_lo_q;
      got_hi_d      = got_hi_q;
      got_lo_d      = got_lo_q;
      frame_valid_d = 1'b0;
      frame_data_d  = frame_data_q;
      seg_err_d     = 1'b0;
      sel_err_d     = 1'b0;
`ifdef SEG_MUX_CAPTURE_TIMEOUT_EN
      stale_d       = stale_q;
`endif

      if (!same)
         stab_cnt_d = '0;
      else if (stab_cnt_q != STAB_MAX)
         stab_cnt_d = stab_cnt_q + 16'd1;

      if (got_hi_q && got_lo_q) begin
         frame_valid_d = 1'b1;
         frame_data_d  = {digit_hi_q, digit_lo_q};
         got_hi_d      = 1'b0;
         got_lo_d      = 1'b0;
      end

`ifdef SEG_MUX_CAPTURE_TIMEOUT_EN
      if (wd_hit) begin
         stale_d    = 1'b1;
         valid_hi_d = 1'b0;
         valid_lo_d = 1'b0;
         got_hi_d   = 1'b0;
         got_lo_d   = 1'b0;
      end
`endif

      if (strobe) begin
         case (cur_sel)
            SEL_HI: begin
               valid_hi_d = dec_ok;
               seg_err_d  = !dec_ok;
               if (dec_ok) begin
                  digit_hi_d = dec_nib;
                  got_hi_d   = 1'b1;
`ifdef SEG_MUX_CAPTURE_TIMEOUT_EN
                  stale_d    = 1'b0;
`endif
               end
            end
            SEL_LO: begin
               valid_lo_d = dec_ok;
               seg_err_d  = !dec_ok;
               if (dec_ok) begin
                  digit_lo_d = dec_nib;
                  got_lo_d   = 1'b1;
`ifdef SEG_MUX_CAPTURE_TIMEOUT_EN
                  stale_d    = 1'b0;
`endif
               end
            end
            default: sel_err_d = 1'b1;
         endcase
      end
   end

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         sync1_q       <= '0;
         sync2_q       <= '0;
         prev_q        <= '0;
         stab_cnt_q    <= '0;
         digit_hi_q    <= '0;
         digit_lo_q    <= '0;
         valid_hi_q    <= 1'b0;
         valid_lo_q    <= 1'b0;
         got_hi_q      <= 1'b0;
         got_lo_q      <= 1'b0;
         frame_valid_q <= 1'b0;
         frame_data_q  <= '0;
         seg_err_q     <= 1'b0;
         sel_err_q     <= 1'b0;
      end else begin
         sync1_q       <= sync1_d;
         sync2_q       <= sync2_d;
         prev_q        <= prev_d;
         stab_cnt_q    <= stab_cnt_d;
         digit_hi_q    <= digit_hi_d;
         digit_lo_q    <= digit_lo_d;
         valid_hi_q    <= valid_hi_d;
         valid_lo_q    <= valid_lo_d;
         got_hi_q      <= got_hi_d;
         got_lo_q      <= got_lo_d;
         frame_valid_q <= frame_valid_d;
         frame_data_q  <= frame_data_d;
         seg_err_q     <= seg_err_d;
         sel_err_q     <= sel_err_d;
      end
   end

   assign digit_hi    = digit_hi_q;
   assign digit_lo    = digit_lo_q;
   assign valid_hi    = valid_hi_q;
   assign valid_lo    = valid_lo_q;
   assign frame_valid = frame_valid_q;
   assign frame_data  = frame_data_q;
   assign seg_err     = seg_err_q;
   assign sel_err     = sel_err_q;

endmodule

// File: tb/tb_seg_mux_capture.sv
// Scoreboard bench for seg_mux_capture with STABLE_CYCLES=4.
module tb_seg_mux_capture;

   logic       clk = 1'b0;
   logic       rst;
   logic [6:0] seg;
   logic [1:0] sel;
   logic [3:0] digit_hi, digit_lo;
   logic       valid_hi, valid_lo;
   logic       frame_valid;
   logic [7:0] frame_data;
   logic       seg_err, sel_err, stale;

   int checks = 0;
   int errors = 0;

   logic [7:0] exp_q[$];
   logic [7:0] obs_q[$];
   int         seg_n = 0;
   int         sel_n = 0;
   int         lo_chg = 0;
   logic [3:0] last_lo = 4'h0;
   bit         saw_two = 1'b0;

   seg_mux_capture #(
      .STABLE_CYCLES  (4),
      .TIMEOUT_CYCLES (50)
   ) dut (
      .CLOCK_50    (clk),
      .reset       (rst),
      .seg_in      (seg),
      .sel_in      (sel),
      .digit_hi    (digit_hi),
      .digit_lo    (digit_lo),
      .valid_hi    (valid_hi),
      .valid_lo    (valid_lo),
      .frame_valid (frame_valid),
      .frame_data  (frame_data),
      .seg_err     (seg_err),
      .sel_err     (sel_err),
      .stale       (stale)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (!rst) begin
         if (frame_valid) obs_q.push_back(frame_data);
         if (seg_err) seg_n++;
         if (sel_err) sel_n++;
         if (digit_lo != last_lo) lo_chg++;
         if (valid_hi && digit_hi == 4'h2) saw_two = 1'b1;
      end
      last_lo = digit_lo;
   end

   task automatic hold(input logic [1:0] s, input logic [6:0] g, input int n);
      @(negedge clk);
      sel = s;
      seg = g;
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic test_reset;
      int n;
      rst = 1'b1;
      sel = 2'b01;
      seg = 7'h6F;
      repeat (3) @(posedge clk);
      hold(2'b01, 7'h6F, 0);
      rst = 1'b0;
      hold(2'b01, 7'h6F, 10);
      checks++;
      if (digit_hi !== 4'h9 || valid_hi !== 1'b1) begin
         errors++;
         $display("FAIL pre_reset_cap: hi=%h v=%b want 9/1", digit_hi, valid_hi);
      end
      hold(2'b01, 7'h06, 4);
      @(posedge clk);
      #2 rst = 1'b1;
      seg = 7'h6F;
      #1;
      checks++;
      if ({digit_hi, digit_lo, valid_hi, valid_lo, frame_valid, frame_data,
           seg_err, sel_err, stale} !== '0) begin
         errors++;
         $display("FAIL async_reset: hi=%h lo=%h vh=%b vl=%b fv=%b fd=%h",
                  digit_hi, digit_lo, valid_hi, valid_lo, frame_valid, frame_data);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      n = 0;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (valid_hi) begin
            n = i;
            break;
         end
      end
      checks++;
      if (n != 7 || digit_hi !== 4'h9) begin
         errors++;
         $display("FAIL reset_latency: edges=%0d hi=%h want 7/9", n, digit_hi);
      end
   endtask

   task automatic test_frame;
      logic [7:0] e;
      hold(2'b01, 7'h4F, 10);
      checks++;
      if (digit_hi !== 4'h3 || valid_hi !== 1'b1 || obs_q.size() != 0) begin
         errors++;
         $display("FAIL hi_capture: hi=%h v=%b frames=%0d want 3/1/0",
                  digit_hi, valid_hi, obs_q.size());
      end
      exp_q.push_back(8'h3B);
      hold(2'b10, 7'h7C, 10);
      checks++;
      if (digit_lo !== 4'hB || valid_lo !== 1'b1) begin
         errors++;
         $display("FAIL lo_capture: lo=%h v=%b want b/1", digit_lo, valid_lo);
      end
      checks++;
      if (obs_q.size() != 1) begin
         errors++;
         $display("FAIL frame_count_hl: got %0d want 1", obs_q.size());
      end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (obs_q[0] !== e) begin
            errors++;
            $display("FAIL frame_hl: got %h want %h", obs_q[0], e);
         end
         void'(obs_q.pop_front());
      end
   endtask

   task automatic test_glitch;
      hold(2'b01, 7'h5B, 3);
      hold(2'b01, 7'h06, 10);
      checks++;
      if (digit_hi !== 4'h1 || saw_two || obs_q.size() != 0) begin
         errors++;
         $display("FAIL glitch: hi=%h saw2=%b frames=%0d want 1/0/0",
                  digit_hi, saw_two, obs_q.size());
      end
   endtask

   task automatic test_errors;
      int s0, e0;
      s0 = seg_n;
      e0 = sel_n;
      hold(2'b01, 7'h00, 10);
      checks++;
      if (seg_n - s0 != 1 || sel_n != e0 || valid_hi !== 1'b0 ||
          digit_hi !== 4'h1) begin
         errors++;
         $display("FAIL seg_err: pulses=%0d vh=%b hi=%h want 1/0/1",
                  seg_n - s0, valid_hi, digit_hi);
      end
      s0 = seg_n;
      hold(2'b11, 7'h3F, 10);
      checks++;
      if (sel_n - e0 != 1 || seg_n != s0 || digit_hi !== 4'h1 ||
          digit_lo !== 4'hB || valid_lo !== 1'b1 || valid_hi !== 1'b0) begin
         errors++;
         $display("FAIL sel_err: pulses=%0d hi=%h lo=%h vl=%b want 1/1/b/1",
                  sel_n - e0, digit_hi, digit_lo, valid_lo);
      end
   endtask

   task automatic test_hold_long;
      int c0, e0;
      logic [7:0] e;
      c0 = lo_chg;
      exp_q.push_back(8'h14);
      hold(2'b10, 7'h66, 100);
      checks++;
      if (lo_chg - c0 != 1 || digit_lo !== 4'h4 || obs_q.size() != 1) begin
         errors++;
         $display("FAIL long_hold_lo: chg=%0d lo=%h frames=%0d want 1/4/1",
                  lo_chg - c0, digit_lo, obs_q.size());
      end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (obs_q[0] !== e) begin
            errors++;
            $display("FAIL frame_long: got %h want %h", obs_q[0], e);
         end
         void'(obs_q.pop_front());
      end
      e0 = sel_n;
      hold(2'b11, 7'h06, 100);
      checks++;
      if (sel_n - e0 != 1) begin
         errors++;
         $display("FAIL long_hold_strobe: sel_err pulses=%0d want 1", sel_n - e0);
      end
   endtask

   task automatic test_back_to_back;
      logic [7:0] e;
      exp_q.push_back(8'hDC);
      hold(2'b10, 7'h39, 10);
      checks++;
      if (digit_lo !== 4'hC || obs_q.size() != 0) begin
         errors++;
         $display("FAIL lo_first: lo=%h frames=%0d want c/0", digit_lo, obs_q.size());
      end
      hold(2'b01, 7'h5E, 10);
      checks++;
      if (digit_hi !== 4'hD || valid_hi !== 1'b1 || obs_q.size() != 1) begin
         errors++;
         $display("FAIL hi_second: hi=%h v=%b frames=%0d want d/1/1",
                  digit_hi, valid_hi, obs_q.size());
      end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (obs_q[0] !== e) begin
            errors++;
            $display("FAIL frame_lh: got %h want %h", obs_q[0], e);
         end
         void'(obs_q.pop_front());
      end
   endtask

   task automatic test_stale;
      hold(2'b01, 7'h5E, 60);
`ifdef SEG_MUX_CAPTURE_TIMEOUT_EN
      checks++;
      if (stale !== 1'b1 || valid_hi !== 1'b0 || valid_lo !== 1'b0) begin
         errors++;
         $display("FAIL stale_set: stale=%b vh=%b vl=%b want 1/0/0",
                  stale, valid_hi, valid_lo);
      end
      hold(2'b10, 7'h3F, 10);
      checks++;
      if (stale !== 1'b0 || valid_lo !== 1'b1 || digit_lo !== 4'h0) begin
         errors++;
         $display("FAIL stale_clear: stale=%b vl=%b lo=%h want 0/1/0",
                  stale, valid_lo, digit_lo);
      end
`else
      checks++;
      if (stale !== 1'b0 || valid_hi !== 1'b1 || valid_lo !== 1'b1) begin
         errors++;
         $display("FAIL no_watchdog: stale=%b vh=%b vl=%b want 0/1/1",
                  stale, valid_hi, valid_lo);
      end
`endif
   endtask

   initial begin
      rst = 1'b1;
      sel = 2'b01;
      seg = 7'h6F;
      test_reset();
      test_frame();
      test_glitch();
      test_errors();
      test_hold_long();
      test_back_to_back();
      test_stale();
      checks++;
      if (exp_q.size() != 0 || obs_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: pending=%0d extra=%0d want 0/0",
                  exp_q.size(), obs_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
